store_handler: RTL and testbench

STORE_HANDLER -- requirements
Module: store_handler

---
 rtl/store_handler.sv | 155 +++++++++++++++
 tb/tb_store_handler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/store_handler.sv
// Purpose: eight-product store with owner restock, buy with revenue accumulation, and price change.
// Latency: one operation per clock edge; the result is visible on the outputs one cycle after sampling.
// Backpressure: none; every edge executes the presented mode, and rejected operations pulse error.
module store_handler (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [2:0]  productCode,
  input  logic [3:0]  itemCount,
  input  logic [3:0]  newPrice,
  output logic [7:0]  stockOut,
  output logic [3:0]  priceOut,
  output logic [7:0]  cost,
  output logic [15:0] revenue,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    MODE_CHARGE = 2'd0,
    MODE_BUY    = 2'd1,
    MODE_PRICE  = 2'd2,
    MODE_IDLE   = 2'd3
  } mode_e;

  localparam int NUM_PRODUCTS = 8;

  // Per-product state.
  logic [7:0]  stock_q [NUM_PRODUCTS];
  logic [7:0]  stock_d [NUM_PRODUCTS];
  logic [3:0]  price_q [NUM_PRODUCTS];
  logic [3:0]  price_d [NUM_PRODUCTS];

  // Accumulator and registered outputs.
  logic [15:0] revenue_q,   revenue_d;
  logic [7:0]  cost_q,      cost_d;
  logic [7:0]  stock_out_q, stock_out_d;
  logic [3:0]  price_out_q, price_out_d;
  logic        done_q,      done_d;
  logic        error_q,     error_d;

  // Views of the addressed product and the arithmetic each operation needs.
  mode_e       op;
  logic [7:0]  cur_stock;
  logic [3:0]  cur_price;
  logic [8:0]  charge_sum;
  logic        charge_ok;
  logic        buy_ok;
  logic [7:0]  buy_cost;
  logic [7:0]  buy_left;

  // Decode the addressed product and precompute the candidate results.
  always_comb begin
    op         = mode_e'(mode);
    cur_stock  = stock_q[productCode];
    cur_price  = price_q[productCode];
    // Nine-bit sum so a restock past 255 is caught instead of wrapping.
    charge_sum = {1'b0, cur_stock} + {5'b0, itemCount};
    charge_ok  = ~charge_sum[8];
    buy_ok     = ({4'b0, itemCount} <= cur_stock);
    // Full-width product: 15 * 15 = 225 still fits in eight bits.
    buy_cost   = {4'b0, itemCount} * {4'b0, cur_price};
    buy_left   = cur_stock - {4'b0, itemCount};
  end

  // Next-state and next-output logic for the operation on this edge.
  always_comb begin
    stock_d     = stock_q;
    price_d     = price_q;
    revenue_d   = revenue_q;
    cost_d      = 8'd0;
    stock_out_d = stock_out_q;
    price_out_d = price_out_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    unique case (op)
      MODE_CHARGE: begin
        price_out_d = cur_price;
        if (charge_ok) begin
          stock_d[productCode] = charge_sum[7:0];
          stock_out_d          = charge_sum[7:0];
          done_d               = 1'b1;
        end else begin
          stock_out_d = cur_stock;
          error_d     = 1'b1;
        end
      end

      MODE_BUY: begin
        price_out_d = cur_price;
        if (buy_ok) begin
          stock_d[productCode] = buy_left;
          stock_out_d          = buy_left;
          cost_d               = buy_cost;
          // Revenue wraps modulo 2^16 by construction of the 16-bit add.
          revenue_d            = revenue_q + {8'd0, buy_cost};
          done_d               = 1'b1;
        end else begin
          stock_out_d = cur_stock;
          error_d     = 1'b1;
        end
      end

      MODE_PRICE: begin
        price_d[productCode] = newPrice;
        price_out_d          = newPrice;
        stock_out_d          = cur_stock;
        done_d               = 1'b1;
      end

      MODE_IDLE: begin
        // Nothing changes; displayed stock and price hold.
      end

      default: begin
      end
    endcase
  end

  // State and output registers; reset wins over any operation on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= 8'd0;
        price_q[i] <= 4'(i + 1);
      end
      revenue_q   <= 16'd0;
      cost_q      <= 8'd0;
      stock_out_q <= 8'd0;
      price_out_q <= 4'd1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= stock_d[i];
        price_q[i] <= price_d[i];
      end
      revenue_q   <= revenue_d;
      cost_q      <= cost_d;
      stock_out_q <= stock_out_d;
      price_out_q <= price_out_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign stockOut = stock_out_q;
  assign priceOut = price_out_q;
  assign cost     = cost_q;
  assign revenue  = revenue_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_store_handler.sv
// Bench for store_handler: directed scenarios followed by random operations,
// every output compared against a behavioural store model after each edge.
module tb_store_handler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic [2:0]  productCode = 3'd0;
  logic [3:0]  itemCount = 4'd0;
  logic [3:0]  newPrice = 4'd0;
  logic [7:0]  stockOut;
  logic [3:0]  priceOut;
  logic [7:0]  cost;
  logic [15:0] revenue;
  logic        done;
  logic        error;

  store_handler dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .productCode (productCode),
    .itemCount   (itemCount),
    .newPrice    (newPrice),
    .stockOut    (stockOut),
    .priceOut    (priceOut),
    .cost        (cost),
    .revenue     (revenue),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  // Reference model: plain integers, store rules applied directly.
  int m_stock [8];
  int m_price [8];
  int m_rev;
  int e_stock_out, e_price_out, e_cost, e_done, e_error;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stockOut"}, int'(stockOut), e_stock_out);
    check({tag, ".priceOut"}, int'(priceOut), e_price_out);
    check({tag, ".cost"},     int'(cost),     e_cost);
    check({tag, ".revenue"},  int'(revenue),  m_rev);
    check({tag, ".done"},     int'(done),     e_done);
    check({tag, ".error"},    int'(error),    e_error);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_stock[i] = 0;
      m_price[i] = i + 1;
    end
    m_rev = 0;
    e_stock_out = 0;
    e_price_out = 1;
    e_cost = 0;
    e_done = 0;
    e_error = 0;
  endtask

  task automatic model_op(input int m, input int p, input int c, input int np);
    e_cost  = 0;
    e_done  = 0;
    e_error = 0;
    case (m)
      0: begin
        if (m_stock[p] + c <= 255) begin
          m_stock[p] += c;
          e_done = 1;
        end else e_error = 1;
        e_stock_out = m_stock[p];
        e_price_out = m_price[p];
      end
      1: begin
        if (c <= m_stock[p]) begin
          m_stock[p] -= c;
          e_cost = c * m_price[p];
          m_rev  = (m_rev + e_cost) % 65536;
          e_done = 1;
        end else e_error = 1;
        e_stock_out = m_stock[p];
        e_price_out = m_price[p];
      end
      2: begin
        m_price[p]  = np;
        e_stock_out = m_stock[p];
        e_price_out = m_price[p];
        e_done      = 1;
      end
      default: ;
    endcase
  endtask

  // Present one operation, let one edge pass, update the model, sample after the edge.
  task automatic op(input int m, input int p, input int c, input int np, input string tag);
    mode        = 2'(m);
    productCode = 3'(p);
    itemCount   = 4'(c);
    newPrice    = 4'(np);
    @(posedge clock);
    #1;
    model_op(m, p, c, np);
    check_all(tag);
  endtask

  // Reset with an arbitrary operation on the inputs; the operation must be discarded.
  task automatic do_reset(input int m, input int p, input int c, input int np, input string tag);
    reset       = 1'b1;
    mode        = 2'(m);
    productCode = 3'(p);
    itemCount   = 4'(c);
    newPrice    = 4'(np);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mode  = 2'd3;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int m, p, c, np, r;

    // Reset state, with a charge presented on the reset edge.
    do_reset(0, 0, 10, 0, "rst0");
    do_reset(0, 0, 10, 0, "rst1");

    // Charge p0 by 10.
    op(0, 0, 10, 0, "charge10");
    check("charge10.lit_stock", int'(stockOut), 10);
    check("charge10.lit_done", int'(done), 1);

    // Buy 5 at default price 1.
    op(1, 0, 5, 0, "buy5");
    check("buy5.lit_cost", int'(cost), 5);
    check("buy5.lit_rev", int'(revenue), 5);

    // Reprice to 15, then buy 2.
    op(2, 0, 0, 15, "price15");
    check("price15.lit_price", int'(priceOut), 15);
    op(1, 0, 2, 0, "buy2");
    check("buy2.lit_cost", int'(cost), 30);
    check("buy2.lit_stock", int'(stockOut), 3);
    check("buy2.lit_rev", int'(revenue), 35);

    // Over-buy is rejected.
    op(1, 0, 4, 0, "overbuy");
    check("overbuy.lit_error", int'(error), 1);
    check("overbuy.lit_rev", int'(revenue), 35);

    // Idle holds displayed values and clears cost and pulses.
    op(3, 5, 9, 9, "idle");

    // Zero-count charge and buy are successful no-ops.
    op(0, 2, 0, 0, "charge0");
    op(1, 2, 0, 0, "buy0");

    // Exact emptying buy.
    op(1, 0, 3, 0, "buy_empty");
    check("buy_empty.lit_stock", int'(stockOut), 0);

    // Fill p7 to 250, overflow rejected, then exactly 255.
    for (int i = 0; i < 25; i++) op(0, 7, 10, 0, "fill7");
    check("fill7.lit_stock", int'(stockOut), 250);
    op(0, 7, 10, 0, "ovf7");
    check("ovf7.lit_error", int'(error), 1);
    check("ovf7.lit_stock", int'(stockOut), 250);
    op(0, 7, 5, 0, "top7");
    check("top7.lit_stock", int'(stockOut), 255);

    // Zero price: a later buy succeeds with cost 0.
    op(2, 7, 0, 0, "price0");
    op(1, 7, 9, 0, "buy_free");

    // Random operations, biased toward charges so buys often succeed.
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 9));
      m  = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      p  = int'($urandom_range(0, 7));
      c  = int'($urandom_range(0, 15));
      np = int'($urandom_range(0, 15));
      op(m, p, c, np, "rand");
    end

    // Reset during a buy with stock 5.
    do_reset(0, 0, 0, 0, "rst2");
    op(0, 1, 5, 0, "pre_rst_charge");
    do_reset(1, 1, 3, 0, "rst_buy");
    // Confirm every price and stock returned to defaults via zero-count buys.
    for (int i = 0; i < 8; i++) op(1, i, 0, 0, "post_rst_probe");
    check("post_rst.lit_price7", int'(priceOut), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
